// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// SERIAL_ADDER_SUB_EN (see serial_adder_ctrl) needs nothing from this package.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell sequenced over WIDTH cycles, carry held in a flop.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a-b via ~b and carry-in of 1).
//
// state | meaning
// IDLE  | waiting for start; operands captured on start=1
// RUN   | one bit per cycle, LSB first; last bit also writes s/co
// DONE  | done pulse for one cycle, start ignored, then back to IDLE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             co_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             ci_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load  = sub ? ~b : b;
  assign ci_load = sub ? 1'b1 : ci;
`else
  assign b_load  = b;
  assign ci_load = ci;
`endif

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  assign sum_d = WIDTH'({fa_s, sum_q} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= ci_load;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q     <= sum_d;
            co_q    <= fa_co;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. It accepts two WIDTH-bit operands with a start handshake and sequences a single 1-bit `full_adder` over WIDTH clock cycles, keeping the carry in a flip-flop between cycles. It returns the WIDTH-bit sum, the final carry and a one-cycle done pulse. It sits between a register-level requester and the existing `full_adder` cell, trading latency for a single adder cell.

## Interface
- One clock; reset is synchronous and active-high. Ports are `clk` and `reset`.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on the accepted start
- b  in  WIDTH  operand B; captured on the accepted start
- ci  in  1  initial carry-in; captured on the accepted start
- sub  in  1  subtract request; present only with SERIAL_ADDER_SUB_EN
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the result is valid
- s  out  WIDTH  registered sum; holds until the next completion
- co  out  1  registered final carry; holds until the next completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load a, b, ci into the shift registers A, B and the carry flop.
  - Clear the bit counter and go to RUN.
  - With start=0, remain in IDLE.
- RUN, each cycle:
  - The `full_adder` computes from A[0], B[0] and carry.
  - Its sum bit shifts into the MSB of the sum shift register. A and B shift right. The carry flop is loaded with the `full_adder` carry-out. The counter increments.
- When the counter reaches WIDTH-1:
  - Perform the final bit.
  - Transfer the sum shift register to s and the final carry to co.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored while busy=1, including in DONE. Operands are captured once, so changes to a, b or ci during RUN have no effect.
- Counter width is $clog2(WIDTH+1). The sum is modulo 2^WIDTH; overflow appears only on co.
- Reset, at any time including mid-RUN:
  - state=IDLE, busy=0, done=0, s=0, co=0, counter=0.
  - No done pulse is produced for an aborted operation.

## Timing
- Let E0 be the edge that samples start=1 in IDLE.
- Bits are processed at edges E1..EWIDTH.
- s and co update at edge EWIDTH, and done is high during the cycle that follows it.
- busy is high from E0 through the done cycle, for WIDTH+1 cycles in total.
- Throughput is one operation per WIDTH+2 cycles. If start is held high, the next operation is accepted on the first edge after DONE.
- s and co are stable whenever done=1 and remain stable until the next done.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The `sub` port exists.
  - When sub=1 at capture, B is loaded as ~b, the carry flop is loaded with 1 and ci is ignored. The block then computes a-b.
  - co=1 means no borrow (a >= b, unsigned).
  - sub=0 gives a normal addition.
- SERIAL_ADDER_SUB_EN undefined: no `sub` port and addition only.

## Structure
- Package `serial_adder_pkg`: state enum `state_t` {IDLE, RUN, DONE}.
- Sub-module: one instance of the existing `full_adder` (ports a, b, ci, s, co), driven from A[0], B[0] and the carry flop.
- Everything else (shift registers, counter, FSM) lives in `serial_adder_ctrl`.

## Test plan
All scenarios use WIDTH=8.
- Reset held 2 cycles → busy=0, done=0, s=8'h00, co=0; start while reset=1 is ignored.
- a=8'h35, b=8'h4A, ci=0, start pulse → done exactly 8 edges after E0, s=8'h7F, co=0, busy high 9 cycles.
- a=8'hFF, b=8'h01, ci=0 → s=8'h00, co=1. Then a=8'hFF, b=8'hFF, ci=1 → s=8'hFF, co=1.
- start held high, a and b changed every cycle during RUN → result matches the E0 operands; the next capture happens on the first edge after DONE; no second done until 10 cycles later.
- reset asserted 4 cycles into RUN → next cycle busy=0, no done pulse, s=8'h00; a fresh start then completes correctly.
- With SERIAL_ADDER_SUB_EN: a=8'h10, b=8'h03, sub=1 → s=8'h0D, co=1. a=8'h03, b=8'h10, sub=1 → s=8'hF3, co=0.
